// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset datapath: FSM states, opcodes and the
// control-field encodings driven by the external control unit.
package mc_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StTrap
  } mc_state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // mem_to_reg: rd source select
  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMdr = 2'd1;
  localparam logic [1:0] WbPc4 = 2'd2;

  // data_size mirrors the load/store funct3 field
  localparam logic [2:0] SizeB  = 3'd0;
  localparam logic [2:0] SizeH  = 3'd1;
  localparam logic [2:0] SizeW  = 3'd2;
  localparam logic [2:0] SizeBu = 3'd4;
  localparam logic [2:0] SizeHu = 3'd5;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  localparam logic [2:0] BrNever  = 3'd0;
  localparam logic [2:0] BrEq     = 3'd1;
  localparam logic [2:0] BrNe     = 3'd2;
  localparam logic [2:0] BrLt     = 3'd3;
  localparam logic [2:0] BrGe     = 3'd4;
  localparam logic [2:0] BrLtu    = 3'd5;
  localparam logic [2:0] BrGeu    = 3'd6;
  localparam logic [2:0] BrAlways = 3'd7;

endpackage

// File: rtl/mc_imm_gen.sv
// Immediate generator: decodes the I/S/B/J/U immediate from IR and sign-extends it to XLEN.
module mc_imm_gen import mc_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] ext_imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (ir[6:0])
      OpLoad, OpImm, OpJalr: imm32 = {{20{ir[31]}}, ir[31:20]};
      OpStore:               imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OpBranch:              imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OpJal:                 imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OpLui, OpAuipc:        imm32 = {ir[31:12], 12'b0};
      default:               imm32 = '0;
    endcase
  end

  assign ext_imm = XLEN'($signed(imm32));

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset datapath (FETCH/DECODE/EXECUTE/MEM/WB) with ready-handshaked data bus.
// Define MISALIGN_TRAP_EN to add the TRAP state and the trap_o output for misaligned accesses/targets.
module multicycle_datapath import mc_pkg::*; #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     REG_ADDR_W = 3,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      branch_cond,
  input  logic            data_read_en,
  input  logic            data_write_en,
  input  logic            reg_write_en,
  input  logic [2:0]      data_size,
  input  logic [1:0]      mem_to_reg,
  input  logic            alu_a_src,
  input  logic            alu_b_src,
  input  logic [3:0]      alu_op,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [2:0]      bus_size,
  output logic            bus_read_en,
  output logic            bus_write_en,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ready,
`ifdef MISALIGN_TRAP_EN
  output logic            trap_o,
`endif
  output logic            retire
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;
  localparam int unsigned ShW     = $clog2(XLEN);

  mc_state_e state_q, state_d;

  logic [XLEN-1:0] pc_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0]     ir_q;
  logic            take_q;
  logic [2:0]      size_q;
  logic [XLEN-1:0] rf_q [NumRegs];

  logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]       rs1_val, rs2_val, ext_imm, a_mux, b_mux, alu_res, pc_plus4, wb_data;
  logic                  take_now;

  function automatic logic [XLEN-1:0] alu(input logic [3:0] op, input logic [XLEN-1:0] x,
                                          input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    logic [ShW-1:0]  sh;
    sh = y[ShW-1:0];
    r  = '0;
    case (op)
      AluSub:   r = x - y;
      AluSll:   r = x << sh;
      AluSlt:   r[0] = $signed(x) < $signed(y);
      AluSltu:  r[0] = x < y;
      AluXor:   r = x ^ y;
      AluSrl:   r = x >> sh;
      AluSra:   r = $signed(x) >>> sh;
      AluOr:    r = x | y;
      AluAnd:   r = x & y;
      AluPassB: r = y;
      default:  r = x + y;
    endcase
    return r;
  endfunction

  function automatic logic branch_comp(input logic [2:0] c, input logic [XLEN-1:0] x,
                                       input logic [XLEN-1:0] y);
    logic t;
    case (c)
      BrEq:     t = (x == y);
      BrNe:     t = (x != y);
      BrLt:     t = $signed(x) < $signed(y);
      BrGe:     t = $signed(x) >= $signed(y);
      BrLtu:    t = x < y;
      BrGeu:    t = x >= y;
      BrAlways: t = 1'b1;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

  // The bus returns load data right-justified; size/sign handling happens at writeback.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] sz, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (sz)
      SizeB:   r = {{(XLEN-8){d[7]}}, d[7:0]};
      SizeH:   r = {{(XLEN-16){d[15]}}, d[15:0]};
      SizeBu:  r = {{(XLEN-8){1'b0}}, d[7:0]};
      SizeHu:  r = {{(XLEN-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  mc_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .ir      (ir_q),
    .ext_imm (ext_imm)
  );

  // Operands are read in DECODE straight from the incoming instruction word.
  assign rs1_idx  = imem_rdata[15 +: REG_ADDR_W];
  assign rs2_idx  = imem_rdata[20 +: REG_ADDR_W];
  assign rd_idx   = ir_q[7 +: REG_ADDR_W];
  assign rs1_val  = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
  assign rs2_val  = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

  assign a_mux    = alu_a_src ? pc_q : a_q;
  assign b_mux    = alu_b_src ? ext_imm : b_q;
  assign alu_res  = alu(alu_op, a_mux, b_mux);
  assign take_now = branch_comp(branch_cond, a_q, b_q);
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    case (mem_to_reg)
      WbMdr:   wb_data = load_ext(size_q, mdr_q);
      WbPc4:   wb_data = pc_plus4;
      default: wb_data = aluout_q;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    if (data_read_en || data_write_en) begin
      if (data_size[1:0] == 2'b10)      misalign = |alu_res[1:0];
      else if (data_size[1:0] == 2'b01) misalign = alu_res[0];
    end else if (take_now) begin
      misalign = |alu_res[1:0];
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    bus_read_en  = 1'b0;
    bus_write_en = 1'b0;
    retire       = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_o       = 1'b0;
`endif
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExecute;
      StExecute: begin
        state_d = (data_read_en || data_write_en) ? StMem : StWb;
`ifdef MISALIGN_TRAP_EN
        if (misalign) state_d = StTrap;
`endif
      end
      StMem: begin
        bus_read_en  = data_read_en;
        bus_write_en = data_write_en & ~data_read_en;
        if (bus_ready) state_d = StWb;
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StTrap: begin
`ifdef MISALIGN_TRAP_EN
        trap_o  = 1'b1;
`endif
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      take_q   <= 1'b0;
      size_q   <= '0;
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StDecode: begin
          ir_q <= imem_rdata;
          a_q  <= rs1_val;
          b_q  <= rs2_val;
        end
        StExecute: begin
          aluout_q <= alu_res;
          take_q   <= take_now;
          size_q   <= data_size;
        end
        StMem: begin
          if (bus_ready && data_read_en) mdr_q <= bus_rdata;
        end
        StWb: begin
          if (reg_write_en && (rd_idx != '0)) rf_q[rd_idx] <= wb_data;
          pc_q <= take_q ? {aluout_q[XLEN-1:1], 1'b0} : pc_plus4;
        end
        StTrap:  pc_q <= TRAP_VEC;
        default: ;
      endcase
    end
  end

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign imem_addr = pc_q;
  assign bus_addr  = aluout_q;
  assign bus_wdata = b_q;
  assign bus_size  = size_q;

endmodule
